split_unpacker: RTL and testbench
=================================

Name: split_unpacker

Overview:
- Inverse of the concat blocks: accepts one packed word of N fields, each W bits wide, and emits the fields one per beat on a W-bit stream.
- Default order is MSB field first, so the word {a, b} comes out as a, then b.
- Sits between a word producer and a narrow serial consumer. Both sides use a valid/ready handshake.

Parameters:
- W, 1, width of one field / output beat in bits (W >= 1)
- N, 3, number of fields per input word (N >= 1)

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset; block is in reset while reset == 0
- in_data  input  N*W  packed word; field k occupies bits [(k+1)*W-1 : k*W]
- in_valid  input  1  in_data is valid
- in_ready  output  1  block accepts in_data this cycle
- out_data  output  W  current field
- out_valid  output  1  out_data is valid
- out_ready  input  1  consumer accepts out_data this cycle
- out_last  output  1  current beat is the final field of the word
- busy  output  1  a word is held and not yet fully emitted

Behaviour:
- Reset (reset == 0, asynchronous): state = IDLE, idx = 0, held word = 0, out_valid = 0, out_data = 0, out_last = 0, busy = 0. Outputs change immediately, without waiting for clk.
- States:
  - IDLE: no word held.
  - EMIT: word held; beat idx is presented.
- Transfers:
  - Input transfer = in_valid && in_ready at a rising edge.
  - Output transfer = out_valid && out_ready at a rising edge.
- in_ready = (state == IDLE) || (output transfer of the last beat this cycle). This is a combinational path from out_ready to in_ready, allowed by design.
- IDLE:
  - in_ready = 1, out_valid = 0.
  - On input transfer: capture in_data, idx = 0, go to EMIT.
- EMIT:
  - out_valid = 1.
  - out_data = field (N-1-idx) of the held word, i.e. MSB field first.
  - out_last = (idx == N-1).
- Output transfer with idx < N-1: idx increments and the next field appears the following cycle.
- Output transfer with idx == N-1:
  - If an input transfer occurs in the same cycle: capture the new word, idx = 0, stay in EMIT. Back-to-back words flow with no bubble.
  - Otherwise: go to IDLE.
- Backpressure: while out_valid && !out_ready, out_data, out_last and idx hold stable.
- in_data changes while in EMIT (not last beat) are ignored. in_ready = 0, so no data is lost.
- N == 1: every beat has out_last = 1. Throughput is one word per cycle.
- idx width = max(1, clog2(N)). idx never exceeds N-1 and does not wrap silently.
- Latency: first field valid the cycle after the input transfer. A word takes N cycles to drain at full rate.
- busy = (state == EMIT).
- Reset mid-word: the held word is discarded. After release, the next accepted word starts at field N-1.

Optional Feature:
- Macro: SPLIT_UNPACKER_LSB_FIRST_EN
- Defined: fields are emitted LSB first, so out_data = field idx. out_last and the handshake are unchanged.
- Undefined: MSB first, as specified above.

Decomposition:
- Package split_pkg holds:
  - state enum (IDLE, EMIT)
  - function idx_width(n) returning max(1, clog2(n))
- One natural sub-module, split_slice_mux: a combinational selector from (word, idx) to a W-bit field, which absorbs the LSB_FIRST ordering.
- The FSM, counter and handshake stay in split_unpacker.

Test Plan:
- W=1, N=3, in_data=3'b101, out_ready=1 -> out_data 1,0,1 on three consecutive cycles; out_last=1 only on the third; then out_valid=0.
- in_data=3'b101, out_ready held 0 for 2 cycles after the first beat -> out_data stays 1 with out_valid=1, idx unchanged; sequence then completes 0,1.
- Back-to-back 3'b101 then 3'b110, in_valid=1, out_ready=1 -> stream 1,0,1,1,1,0 in six consecutive cycles; in_ready=1 exactly in the cycle of the first word's last beat.
- in_data=3'b011 accepted; after one beat pull reset low mid-cycle -> out_valid=0 and busy=0 immediately. After release, in_data=3'b110 -> 1,1,0.
- In EMIT, drive in_valid=1 with 3'b111 while first word 3'b100 drains -> in_ready=0 until last beat; output 1,0,0,1,1,1 with no loss or corruption.
- SPLIT_UNPACKER_LSB_FIRST_EN defined, in_data=3'b110 -> out_data 0,1,1; out_last=1 on the third beat.

Source files
------------

// File: rtl/split_pkg.sv
// Shared types and helpers for the split_unpacker word-to-field serializer.
package split_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      EMIT = 1'b1
   } state_t;

   // Index counter width: enough bits to count 0..n-1, never narrower than one bit.
   function automatic int unsigned idx_width(input int unsigned n);
      return (n <= 1) ? 32'd1 : 32'($clog2(n));
   endfunction

endpackage

// File: rtl/split_slice_mux.sv
// Field selector: picks the W-bit field presented on beat idx of a packed N-field word.
// Optional macro SPLIT_UNPACKER_LSB_FIRST_EN: beat idx carries field idx (LSB first);
// otherwise beat idx carries field N-1-idx (MSB first).
module split_slice_mux
   import split_pkg::*;
#(
   parameter int unsigned W = 1,
   parameter int unsigned N = 3
) (
   input  logic [N*W-1:0]            word,
   input  logic [idx_width(N)-1:0]   idx,
   output logic [W-1:0]              field
);

   logic [31:0] sel;

   // Map the beat index to the field position in the packed word.
`ifdef SPLIT_UNPACKER_LSB_FIRST_EN
   assign sel = 32'(idx);
`else
   assign sel = N - 32'd1 - 32'(idx);
`endif

   // One-hot style select over all field positions; out-of-range sel yields zero.
   always_comb begin
      field = '0;
      for (int unsigned k = 0; k < N; k++) begin
         if (k == sel) begin
            field = word[k*W +: W];
         end
      end
   end

endmodule

// File: rtl/split_unpacker.sv
// split_unpacker: accepts one packed word of N W-bit fields and emits the fields one per beat
// with valid/ready on both sides. Back-to-back words flow without a bubble because in_ready
// rises combinationally when the last beat of the held word is accepted.
// Optional macro SPLIT_UNPACKER_LSB_FIRST_EN selects LSB-first field order (see split_slice_mux).
module split_unpacker
   import split_pkg::*;
#(
   parameter int unsigned W = 1,
   parameter int unsigned N = 3
) (
   input  logic           clk,
   input  logic           reset,
   input  logic [N*W-1:0] in_data,
   input  logic           in_valid,
   output logic           in_ready,
   output logic [W-1:0]   out_data,
   output logic           out_valid,
   input  logic           out_ready,
   output logic           out_last,
   output logic           busy
);

   localparam int unsigned IW = idx_width(N);
   localparam int unsigned DW = N * W;
   localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

   state_t          state_q, state_d;
   logic [IW-1:0]   idx_q, idx_d;
   logic [DW-1:0]   word_q, word_d;
   logic            last_beat;
   logic            out_xfer;
   logic            in_xfer;

   assign last_beat = (idx_q == LAST_IDX);
   assign out_valid = (state_q == EMIT);
   assign out_last  = (state_q == EMIT) && last_beat;
   assign busy      = (state_q == EMIT);

   // State, beat index and held word; reset discards any word in flight.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         idx_q   <= '0;
         word_q  <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         word_q  <= word_d;
      end
   end

   // Next-state, handshake and beat counter.
   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      word_d   = word_q;
      out_xfer = (state_q == EMIT) && out_ready;
      in_ready = (state_q == IDLE) || (out_xfer && last_beat);
      in_xfer  = in_valid && in_ready;

      case (state_q)
         IDLE: begin
            if (in_xfer) begin
               word_d  = in_data;
               idx_d   = '0;
               state_d = EMIT;
            end
         end
         EMIT: begin
            if (out_xfer) begin
               if (last_beat) begin
                  idx_d = '0;
                  if (in_xfer) begin
                     word_d = in_data;
                  end else begin
                     state_d = IDLE;
                  end
               end else begin
                  idx_d = idx_q + IW'(1);
               end
            end
         end
         default: begin
            state_d = IDLE;
            idx_d   = '0;
         end
      endcase
   end

   split_slice_mux #(
      .W (W),
      .N (N)
   ) u_mux (
      .word  (word_q),
      .idx   (idx_q),
      .field (out_data)
   );

endmodule

// File: tb/tb_split_unpacker.sv
// Testbench for split_unpacker: directed test-plan steps followed by random traffic, all
// checked against a queue of expected beats built from each accepted word.
module tb_split_unpacker;

   localparam int unsigned W = 1;
   localparam int unsigned N = 3;

   logic           clk = 1'b0;
   logic           reset;
   logic [N*W-1:0] in_data;
   logic           in_valid;
   logic           in_ready;
   logic [W-1:0]   out_data;
   logic           out_valid;
   logic           out_ready;
   logic           out_last;
   logic           busy;

   typedef struct {
      logic [W-1:0] d;
      logic         l;
   } beat_t;

   beat_t       exp_q[$];
   int          checks = 0;
   int          errors = 0;
   logic [63:0] stream;

   always #5 clk = ~clk;

   split_unpacker #(.W(W), .N(N)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_last  (out_last),
      .busy      (busy)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Expand an accepted word into its beats in emission order.
   task automatic push_word(input logic [N*W-1:0] word);
      beat_t b;
      int unsigned f;
      for (int unsigned k = 0; k < N; k++) begin
`ifdef SPLIT_UNPACKER_LSB_FIRST_EN
         f = k;
`else
         f = N - 1 - k;
`endif
         b.d = W'(word >> (f * W));
         b.l = (k == N - 1);
         exp_q.push_back(b);
      end
   endtask

   // One clock: check outputs at the falling edge, advance the model, step past the rising edge.
   task automatic cycle();
      logic exp_v, exp_ir, in_x, out_x;
      @(negedge clk);
      exp_v  = (exp_q.size() != 0);
      exp_ir = (exp_q.size() == 0) || (exp_q.size() == 1 && out_ready);
      chk("out_valid", 64'(out_valid), 64'(exp_v));
      chk("in_ready", 64'(in_ready), 64'(exp_ir));
      chk("busy", 64'(busy), 64'(exp_v));
      if (exp_v) begin
         chk("out_data", 64'(out_data), 64'(exp_q[0].d));
         chk("out_last", 64'(out_last), 64'(exp_q[0].l));
      end
      in_x  = in_valid && exp_ir;
      out_x = exp_v && out_ready;
      if (out_x) begin
         stream = (stream << W) | 64'(out_data);
         void'(exp_q.pop_front());
      end
      if (in_x) push_word(in_data);
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset     = 1'b0;
      in_data   = '0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      stream    = '0;

      // Reset state
      @(posedge clk);
      #1;
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_out_data", 64'(out_data), 64'd0);
      chk("rst_out_last", 64'(out_last), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      @(posedge clk);
      #1;
      reset = 1'b1;

      // Single word 101 at full rate
      stream = '0;
      in_data = 3'b101; in_valid = 1'b1; out_ready = 1'b1;
      cycle();
      in_valid = 1'b0;
      repeat (4) cycle();
      chk("seq_single", stream, 64'b101);

      // Backpressure on the first beat for two cycles
      stream = '0;
      in_data = 3'b101; in_valid = 1'b1; out_ready = 1'b1;
      cycle();
      in_valid = 1'b0; out_ready = 1'b0;
      repeat (2) cycle();
      out_ready = 1'b1;
      repeat (4) cycle();
      chk("seq_stall", stream, 64'b101);

      // Back-to-back words 101 then 110
      stream = '0;
      in_data = 3'b101; in_valid = 1'b1; out_ready = 1'b1;
      cycle();
      in_data = 3'b110;
      repeat (3) cycle();
      in_valid = 1'b0;
      repeat (4) cycle();
`ifdef SPLIT_UNPACKER_LSB_FIRST_EN
      chk("seq_b2b", stream, 64'b101011);
`else
      chk("seq_b2b", stream, 64'b101110);
`endif

      // Reset in the middle of a word, then a fresh word
      in_data = 3'b011; in_valid = 1'b1; out_ready = 1'b1;
      cycle();
      in_valid = 1'b0;
      cycle();
      #2;
      reset = 1'b0;
      #1;
      chk("midrst_out_valid", 64'(out_valid), 64'd0);
      chk("midrst_busy", 64'(busy), 64'd0);
      chk("midrst_out_data", 64'(out_data), 64'd0);
      chk("midrst_in_ready", 64'(in_ready), 64'd1);
      exp_q.delete();
      @(posedge clk);
      #1;
      reset = 1'b1;
      stream = '0;
      in_data = 3'b110; in_valid = 1'b1;
      cycle();
      in_valid = 1'b0;
      repeat (4) cycle();
`ifdef SPLIT_UNPACKER_LSB_FIRST_EN
      chk("seq_after_rst", stream, 64'b011);
`else
      chk("seq_after_rst", stream, 64'b110);
`endif

      // New word offered while the previous one drains
      stream = '0;
      in_data = 3'b100; in_valid = 1'b1; out_ready = 1'b1;
      cycle();
      in_data = 3'b111;
      repeat (3) cycle();
      in_valid = 1'b0;
      repeat (4) cycle();
`ifdef SPLIT_UNPACKER_LSB_FIRST_EN
      chk("seq_hold_in", stream, 64'b001111);
`else
      chk("seq_hold_in", stream, 64'b100111);
`endif

      // Random traffic on both handshakes
      for (int i = 0; i < 400; i++) begin
         in_valid  = 1'($urandom_range(0, 1));
         in_data   = (N*W)'($urandom);
         out_ready = ($urandom_range(0, 3) != 0);
         cycle();
      end
      in_valid = 1'b0; out_ready = 1'b1;
      repeat (N + 2) cycle();
      chk("drained", 64'(exp_q.size()), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
